keypad_event_ctrl: RTL and testbench
====================================

KEYPAD_EVENT_CTRL -- requirements
Module: keypad_event_ctrl

Interface
REQ-001 Parameter ROWS, default 4, number of row lines driven.
REQ-002 Parameter COLS, default 4, number of column lines sampled.
REQ-003 Parameter SCAN_DIV, default 1000, clock cycles per row slot; SHALL be >= COLS+2.
REQ-004 Parameter DEBOUNCE, default 4, consecutive agreeing samples of a key required to change its state; range 1..15.
REQ-005 Parameter FIFO_DEPTH, default 8, event FIFO entries; power of two, >= 2.
REQ-006 Derived KW = clog2(ROWS*COLS); key index k = r*COLS + c.
REQ-007 clk  in  1  single clock; all logic on rising edge.
REQ-008 rstn  in  1  reset, synchronous, active-low.
REQ-009 col  in  COLS  column sense lines, active-low (0 = key closed on driven row).
REQ-010 row  out  ROWS  row drive, active-low, exactly one bit low outside reset.
REQ-011 rd_en  in  1  pop FIFO head; ignored when FIFO empty.
REQ-012 key_clear  in  1  flush FIFO and clear overflow.
REQ-013 evt_valid  out  1  FIFO non-empty.
REQ-014 evt_data  out  KW+1  FIFO head, show-ahead: bit KW = release (1) / press (0), bits KW-1:0 = key index.
REQ-015 evt_count  out  clog2(FIFO_DEPTH)+1  entries held.
REQ-016 overflow  out  1  sticky: an event was dropped because FIFO was full.
REQ-017 key_state  out  ROWS*COLS  debounced state per key, 1 = pressed.
REQ-018 interrupt_key  out  1  evt_valid | overflow.

Function
REQ-019 Scanner: row counter r (0..ROWS-1) and slot counter s (0..SCAN_DIV-1); row = ~(1<<r); s wraps at SCAN_DIV-1 and r advances, wrapping ROWS-1 -> 0.
REQ-020 col SHALL be latched once per slot at s = SCAN_DIV-COLS-1 (settle time after row change).
REQ-021 Column c of latched sample SHALL be processed at s = SCAN_DIV-COLS+c, one key per cycle, ascending c.
REQ-022 Per key: DEBOUNCE-wide counter; raw==key_state resets counter to 0; raw!=key_state increments; on reaching DEBOUNCE, key_state toggles, counter clears, one event pushed.
REQ-023 Event = {~raw_pressed, k}, i.e. press -> release bit 0, release -> release bit 1.
REQ-024 FIFO: push from REQ-022, pop on rd_en & evt_valid; order preserved; at most one push and one pop per cycle.
REQ-025 Push and pop in same cycle: count unchanged, both take effect, including when full (no overflow).
REQ-026 Push when full without pop: event dropped, overflow set to 1; key_state still updates.
REQ-027 key_clear: next cycle FIFO empty, count 0, overflow 0; a push or pop in the same cycle is discarded (clear wins).
REQ-028 key_clear SHALL NOT affect scanner, debounce counters or key_state.
REQ-029 Pointers wrap modulo FIFO_DEPTH; evt_count covers 0..FIFO_DEPTH exactly.
REQ-030 evt_data SHALL equal 0 when FIFO empty.

Reset
REQ-031 While rstn=0 at a clock edge: row all ones, r=0, s=0, key_state 0, debounce counters 0, FIFO empty, evt_count 0, overflow 0, evt_valid 0, interrupt_key 0, evt_data 0.
REQ-032 First clock edge after rstn rises: row = ~1 (row 0 driven), s=0.
REQ-033 Reset asserted mid-slot or mid-debounce SHALL discard all partial state; no event generated by reset itself.

Verification (ROWS=4, COLS=4, SCAN_DIV=16, DEBOUNCE=3, FIFO_DEPTH=4)
REQ-034 Close key 6 (col[2] low when row[1] low), hold -> after 3rd row-1 sample: evt_data=5'b0_0110, evt_valid=1, interrupt_key=1, key_state[6]=1; open key -> after 3 samples evt 5'b1_0110.
REQ-035 Key 6 toggled every scan (never 3 agreeing samples) -> no event, key_state[6]=0.
REQ-036 Keys 4 and 7 closed simultaneously -> events 4 then 7, pushed 3 cycles apart in one slot; rd_en twice pops in that order, evt_valid=0 after.
REQ-037 5 events, no reads -> evt_count=4, overflow=1, first 4 events retained; key_clear pulse -> evt_count=0, overflow=0, interrupt_key=0, key_state unchanged.
REQ-038 FIFO full, rd_en held in the push cycle -> evt_count stays 4, overflow stays 0, new event at tail.
REQ-039 rstn low for 1 cycle mid-slot with key 6 pressed and FIFO holding 2 -> row=4'b1111 during reset, all outputs at REQ-031 values, key 6 re-detected as press 3 scans later.

Source files
------------

// File: rtl/keypad_event_ctrl.sv
// keypad_event_ctrl: row-scanned key matrix with per-key debounce
// and an event FIFO of press/release codes.
//
// Ports:
//   clk, rstn         clock, synchronous active-low reset
//   col[COLS]         column sense, active-low
//   row[ROWS]         row drive, active-low, one-hot low when running
//   rd_en             pop FIFO head (ignored when empty)
//   key_clear         flush FIFO and overflow flag
//   evt_valid         FIFO non-empty
//   evt_data[KW:0]    FIFO head {release, key index}, 0 when empty
//   evt_count         entries held, 0..FIFO_DEPTH
//   overflow          sticky: an event was dropped on a full FIFO
//   key_state[NK]     debounced key state, 1 = pressed
//   interrupt_key     evt_valid | overflow
module keypad_event_ctrl #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 8,
  localparam int NK = ROWS * COLS,
  localparam int KW = $clog2(NK),
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [COLS-1:0] col,
  output logic [ROWS-1:0] row,
  input  logic            rd_en,
  input  logic            key_clear,
  output logic            evt_valid,
  output logic [KW:0]     evt_data,
  output logic [CW-1:0]   evt_count,
  output logic            overflow,
  output logic [NK-1:0]   key_state,
  output logic            interrupt_key
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SW = $clog2(SCAN_DIV);

  logic          active;
  logic [RW-1:0] r_q;
  logic [SW-1:0] s_q;
  logic [COLS-1:0] col_q;
  logic [3:0]    dcnt [NK];

  logic          proc;
  logic          raw;
  int            cidx;
  logic [KW-1:0] k_idx;
  logic          cur;
  logic          hit;
  logic [KW:0]   evt_in;

  logic [KW:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] cnt_q;
  logic          ovf_q;
  logic          full;
  logic          pop;
  logic          do_push;

  // active holds row drive off for the first cycle after reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      active <= 1'b0;
      r_q    <= '0;
      s_q    <= '0;
    end else if (!active) begin
      active <= 1'b1;
    end else if (s_q == SW'(SCAN_DIV - 1)) begin
      s_q <= '0;
      r_q <= (r_q == RW'(ROWS - 1)) ? '0 : r_q + 1'b1;
    end else begin
      s_q <= s_q + 1'b1;
    end
  end

  always_comb begin
    row = '1;
    if (active) row[r_q] = 1'b0;
  end

  // sample once per slot after the row has settled
  always_ff @(posedge clk) begin
    if (!rstn) col_q <= '1;
    else if (active && s_q == SW'(SCAN_DIV - COLS - 1)) col_q <= col;
  end

  // last COLS cycles of a slot walk the latched columns
  always_comb begin
    proc = 1'b0;
    raw  = 1'b0;
    cidx = 0;
    for (int c = 0; c < COLS; c++) begin
      if (s_q == SW'(SCAN_DIV - COLS + c)) begin
        proc = active;
        raw  = ~col_q[c];
        cidx = c;
      end
    end
    k_idx  = KW'(int'(r_q) * COLS + cidx);
    cur    = key_state[k_idx];
    hit    = proc && (raw != cur) &&
             (dcnt[k_idx] == 4'(DEBOUNCE - 1));
    evt_in = {~raw, k_idx};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      key_state <= '0;
      for (int i = 0; i < NK; i++) dcnt[i] <= '0;
    end else if (proc) begin
      if (raw == cur) begin
        dcnt[k_idx] <= '0;
      end else if (hit) begin
        dcnt[k_idx]      <= '0;
        key_state[k_idx] <= raw;
      end else begin
        dcnt[k_idx] <= dcnt[k_idx] + 4'd1;
      end
    end
  end

  assign full    = (cnt_q == CW'(FIFO_DEPTH));
  assign pop     = rd_en && evt_valid;
  // a full FIFO still accepts when the head leaves this cycle
  assign do_push = hit && (!full || pop);

  always_ff @(posedge clk) begin
    if (!rstn || key_clear) begin
      wp    <= '0;
      rp    <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (do_push && !pop) cnt_q <= cnt_q + 1'b1;
      else if (pop && !do_push) cnt_q <= cnt_q - 1'b1;
      if (hit && full && !pop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && !key_clear && do_push) mem[wp] <= evt_in;
  end

  assign evt_valid     = (cnt_q != '0);
  assign evt_data      = evt_valid ? mem[rp] : '0;
  assign evt_count     = cnt_q;
  assign overflow      = ovf_q;
  assign interrupt_key = evt_valid | ovf_q;

endmodule

// File: tb/tb_keypad_event_ctrl.sv
// tb_keypad_event_ctrl: key-matrix bench with a slot-level model,
// directed scenarios and randomized key/read traffic.
module tb_keypad_event_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rd_en = 1'b0;
  logic        key_clear = 1'b0;
  logic [3:0]  col;
  logic [3:0]  row;
  logic        evt_valid;
  logic [4:0]  evt_data;
  logic [2:0]  evt_count;
  logic        overflow;
  logic [15:0] key_state;
  logic        interrupt_key;

  logic [15:0] pressed = '0;
  int          checks = 0;
  int          errors = 0;
  bit          auto_rd = 0;

  bit          mv;
  int          mt;
  bit [3:0]    mlat;
  int          mcnt [16];
  bit [15:0]   mks;
  bit [4:0]    mq [$];
  bit          movf;

  keypad_event_ctrl #(
    .ROWS(4), .COLS(4), .SCAN_DIV(16),
    .DEBOUNCE(3), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rstn(rstn), .col(col), .row(row),
    .rd_en(rd_en), .key_clear(key_clear),
    .evt_valid(evt_valid), .evt_data(evt_data),
    .evt_count(evt_count), .overflow(overflow),
    .key_state(key_state), .interrupt_key(interrupt_key)
  );

  always #5 clk = ~clk;

  // physical matrix: a closed key pulls its column low on a driven row
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      if (row[r] === 1'b0)
        for (int c = 0; c < 4; c++)
          if (pressed[r*4+c]) col[c] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic void predict(output bit p, output bit [4:0] ev);
    int s, r, k;
    bit raw;
    p  = 0;
    ev = '0;
    if (!mv) return;
    s = mt % 16;
    r = (mt / 16) % 4;
    if (s >= 12) begin
      k   = r * 4 + (s - 12);
      raw = mlat[s-12];
      if (raw != mks[k] && mcnt[k] + 1 == 3) begin
        p  = 1;
        ev = {~raw, 4'(k)};
      end
    end
  endfunction

  task automatic model_update(input bit p, input bit [4:0] ev);
    int s, r, k;
    bit raw, dp, full;
    if (!rstn) begin
      mv = 0; mt = 0; mlat = '0; mks = '0; movf = 0;
      for (int i = 0; i < 16; i++) mcnt[i] = 0;
      mq.delete();
      return;
    end
    if (mv) begin
      s = mt % 16;
      r = (mt / 16) % 4;
      if (s >= 12) begin
        k   = r * 4 + (s - 12);
        raw = mlat[s-12];
        if (raw == mks[k]) mcnt[k] = 0;
        else if (mcnt[k] + 1 == 3) begin
          mcnt[k] = 0;
          mks[k]  = ~mks[k];
        end else mcnt[k]++;
      end
      if (s == 11)
        for (int c = 0; c < 4; c++) mlat[c] = pressed[r*4+c];
    end
    if (key_clear) begin
      mq.delete();
      movf = 0;
    end else begin
      dp   = rd_en && mq.size() > 0;
      full = mq.size() == 4;
      if (dp) void'(mq.pop_front());
      if (p) begin
        if (!full || dp) mq.push_back(ev);
        else movf = 1;
      end
    end
    if (!mv) begin
      mv = 1;
      mt = 0;
    end else mt++;
  endtask

  task automatic tick;
    bit p;
    bit [4:0] ev;
    logic [3:0] erow;
    predict(p, ev);
    if (auto_rd) rd_en = p;
    model_update(p, ev);
    @(posedge clk);
    #1;
    erow = mv ? ~(4'b0001 << ((mt / 16) % 4)) : 4'hF;
    chk("row", row, erow);
    chk("evt_valid", evt_valid, mq.size() != 0);
    chk("evt_data", evt_data, mq.size() != 0 ? mq[0] : 5'd0);
    chk("evt_count", evt_count, mq.size());
    chk("overflow", overflow, movf);
    chk("key_state", key_state, mks);
    chk("interrupt_key", interrupt_key, mq.size() != 0 || movf);
    if (auto_rd) rd_en = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic pop1;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic clr;
    key_clear = 1'b1;
    tick();
    key_clear = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    run(3);
    chk("rst_row", row, 4'hF);
    chk("rst_valid", evt_valid, 1'b0);
    rstn = 1'b1;
    tick();
    chk("first_row", row, 4'hE);

    pressed = 16'h0040;
    run(256);
    chk("k6_press", evt_data, 5'h06);
    chk("k6_state", key_state[6], 1'b1);
    chk("k6_irq", interrupt_key, 1'b1);
    pressed = 16'h0000;
    run(256);
    chk("k6_cnt", evt_count, 3'd2);
    pop1();
    chk("k6_release", evt_data, 5'h16);
    pop1();
    chk("k6_empty", evt_valid, 1'b0);

    for (int i = 0; i < 8; i++) begin
      pressed[6] = ~pressed[6];
      run(64);
    end
    chk("toggle_cnt", evt_count, 3'd0);
    chk("toggle_state", key_state[6], 1'b0);

    pressed = 16'h0090;
    run(256);
    chk("k47_cnt", evt_count, 3'd2);
    chk("k47_first", evt_data, 5'h04);
    pop1();
    chk("k47_second", evt_data, 5'h07);
    pop1();
    chk("k47_empty", evt_valid, 1'b0);
    pressed = 16'h0000;
    run(256);
    clr();

    pressed = 16'h002F;
    run(256);
    chk("ovf_cnt", evt_count, 3'd4);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_head", evt_data, 5'h00);
    pop1();
    chk("ovf_next", evt_data, 5'h01);
    clr();
    chk("clr_cnt", evt_count, 3'd0);
    chk("clr_ovf", overflow, 1'b0);
    chk("clr_irq", interrupt_key, 1'b0);
    chk("clr_keys", key_state, 16'h002F);

    pressed = 16'h0020;
    run(256);
    chk("full_cnt", evt_count, 3'd4);
    auto_rd = 1;
    pressed = 16'h0060;
    run(256);
    auto_rd = 0;
    chk("pp_cnt", evt_count, 3'd4);
    chk("pp_ovf", overflow, 1'b0);
    pop1();
    pop1();
    pop1();
    chk("pp_tail", evt_data, 5'h06);
    clr();

    pressed = 16'h0240;
    run(256);
    chk("pre_rst_cnt", evt_count, 3'd2);
    run(5);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("mid_rst_row", row, 4'hF);
    chk("mid_rst_cnt", evt_count, 3'd0);
    chk("mid_rst_data", evt_data, 5'h00);
    chk("mid_rst_keys", key_state, 16'h0000);
    chk("mid_rst_irq", interrupt_key, 1'b0);
    run(256);
    chk("redetect", evt_data, 5'h06);
    chk("redetect_cnt", evt_count, 3'd2);

    for (int i = 0; i < 30; i++) begin
      pressed = 16'($urandom & $urandom & $urandom);
      repeat ($urandom_range(40, 200)) begin
        rd_en     = ($urandom_range(0, 3) == 0);
        key_clear = ($urandom_range(0, 60) == 0);
        tick();
      end
      rd_en     = 1'b0;
      key_clear = 1'b0;
      if ($urandom_range(0, 9) == 0) begin
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
